// File: rtl/jump_input_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | jump_input_conditioner: sync/debounce button and pause, frame-held jump |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module jump_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_FRAMES     = 2,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_button_raw,
  input  logic        i_pause_raw,
  input  logic        i_screen_ready,
  input  logic        i_game_over,
  output logic        o_jump_req,
  output logic        o_pause_level,
  output logic [15:0] o_press_count
);

  localparam int FR_W = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES);
  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FR_W-1:0]  c_FR_LAST = FR_W'(HOLD_FRAMES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0] w_raw;
  logic [1:0] w_deb;
  logic [1:0] w_flip;

  assign w_raw = {i_pause_raw, i_button_raw};

  // Bit 0 = button, bit 1 = pause; each gets its own synchroniser and debouncer.
  for (genvar g = 0; g < 2; g++) begin : g_deb
    logic             r_s1;
    logic             r_s2;
    logic             r_deb;
    logic [CNT_W-1:0] r_cnt;

    assign w_flip[g] = (r_s2 != r_deb) && (r_cnt == c_CNT_MAX);
    assign w_deb[g]  = r_deb;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_s1  <= 1'b0;
        r_s2  <= 1'b0;
        r_deb <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_s1 <= w_raw[g];
        r_s2 <= r_s1;
        if (r_s2 == r_deb) begin
          r_cnt <= '0;
        end else if (w_flip[g]) begin
          r_cnt <= '0;
          r_deb <= ~r_deb;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  logic            r_sr_prev;
  logic            r_press;
  logic            w_tick;
  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [FR_W-1:0] r_frames;
  logic [FR_W-1:0] w_frames_nxt;
  logic            w_accept;
  logic [15:0]     r_press_count;

  assign w_tick = i_screen_ready & ~r_sr_prev;

  // Press event is registered alongside the debounced rise; game_over is sampled there.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr_prev <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_sr_prev <= i_screen_ready;
      r_press   <= w_flip[0] & ~w_deb[0] & ~i_game_over;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_frames <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_frames <= w_frames_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_frames_nxt = r_frames;
    w_accept     = 1'b0;
    if (i_game_over) begin
      w_state_nxt  = S_IDLE;
      w_frames_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_press) begin
            w_state_nxt  = S_HOLD;
            w_frames_nxt = '0;
            w_accept     = 1'b1;
          end
        end
        S_HOLD: begin
          if (w_tick && !w_deb[1]) begin
            if (r_frames == c_FR_LAST) begin
              w_state_nxt  = S_WAIT;
              w_frames_nxt = '0;
            end else begin
              w_frames_nxt = r_frames + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (!w_deb[0]) w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt  = S_IDLE;
          w_frames_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    o_jump_req = (r_state == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_press_count <= '0;
    end else if (w_accept && (r_press_count != 16'hFFFF)) begin
      r_press_count <= r_press_count + 16'd1;
    end
  end

  assign o_pause_level = w_deb[1];
  assign o_press_count = r_press_count;

endmodule
`default_nettype wire

// File: doc/jump_input_conditioner.md
Name: jump_input_conditioner

Overview:
Upstream front-end for the game CPU's button and pause registers. It synchronises and debounces the raw push-button and pause switch. Each clean button press becomes a jump request that is held for a fixed number of display frames, so the CPU polling loop cannot miss it. Outputs drive the button bits of r20 and the pause bits of r26 in place of the raw pins, and gate on screen_ready frame ticks and game_over from the top level.

Parameters:
DEBOUNCE_CYCLES, 1000000, clk cycles an input must differ stably from its debounced value before the debounced value flips (10 ms at 100 MHz).
HOLD_FRAMES, 2, number of counted frame ticks jump_req stays high per accepted press (>=1).
CNT_W, 20, width of each debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
clk  input  1  100 MHz system clock; sole clock.
reset  input  1  synchronous, active-high reset.
button_raw  input  1  asynchronous push-button pin.
pause_raw  input  1  asynchronous pause switch pin.
screen_ready  input  1  VGA end-of-frame level; rising edge = frame tick.
game_over  input  1  high when lives are exhausted (r28 == 0).
jump_req  output  1  held jump request to CPU (replaces button_press in r20).
pause_level  output  1  debounced pause switch (replaces pause_switch in r26).
press_count  output  16  accepted presses since reset, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. On reset: sync flops, debounced values, counters, press_count and screen_ready history all go to 0, the FSM goes to IDLE, and jump_req = pause_level = 0.
- Synchroniser: two flops per raw input. Synced value lags the pin by 2 cycles.
- Debounce, per input:
  - Counter clears whenever synced == debounced.
  - Otherwise the counter increments each cycle.
  - On the cycle the counter reaches DEBOUNCE_CYCLES-1, the debounced value flips and the counter clears.
  - Total pin-to-debounced latency = 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- pause_level = debounced pause, registered directly.
- Frame tick = screen_ready high while its previous-cycle value was low.
- Press event = debounced button rising edge: one cycle, registered.
- FSM:
  - IDLE: jump_req=0. On press event with game_over=0 -> HOLD, frame counter = 0, press_count += 1 (saturate at 0xFFFF). A frame tick on the same cycle is not counted.
  - HOLD: jump_req=1. Each frame tick with pause_level=0 increments the frame counter; ticks during pause are ignored, so the hold freezes. When the counter would reach HOLD_FRAMES -> WAIT_RELEASE; jump_req drops the next cycle. New press events are dropped and not counted.
  - WAIT_RELEASE: jump_req=0. Stays until the debounced button is 0, then -> IDLE. There is no auto-repeat while the button is held.
- game_over=1 in any state: next cycle FSM = IDLE, jump_req=0, frame counter = 0. Press events are ignored while game_over=1. press_count is retained.
- A press whose debounced rise coincides with game_over falling is ignored; game_over is sampled on the event cycle.
- press_count changes only on IDLE->HOLD.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, HOLD_FRAMES=2; frame tick every 20 cycles.)
- Clean press: button_raw high held 30 cycles -> debounced rises 6 cycles after the pin; jump_req high the cycle after; drops 1 cycle after the 2nd frame tick; press_count=1.
- Glitch: button_raw high 3 cycles then low -> jump_req stays 0; press_count=0.
- Held button: raw high for 200 cycles -> exactly one hold window; state stays WAIT_RELEASE until release + 6 cycles; press_count=1.
- Pause freeze: press, then pause_raw high before the 1st tick for 100 cycles -> jump_req stays high through all paused ticks; it clears after 2 unpaused ticks once pause_level returns 0.
- Game over: assert game_over mid-HOLD -> jump_req 0 the next cycle. A press while game_over=1 gives jump_req=0 and press_count unchanged.
- Saturation and reset: preload 0xFFFF presses via forced count, press again -> press_count stays 0xFFFF. Assert reset mid-HOLD -> jump_req, pause_level and press_count are 0 the next cycle.
